z2_cycle_ctrl: RTL and testbench
================================

// Module: z2_cycle_ctrl
// PURPOSE
// Parametrised Zorro II slave bus-cycle controller for the MEMCLK domain. Synchronises
// the 68000 strobes, claims the cycle for one of NUM_TARGETS decoded targets and
// sequences IDLE->START->DATA->END. Generates DTACK from the claimed target only.
// Adds abort-on-AS-negation, fixed-priority multi-hit resolution and a watchdog that
// raises BERR when a claimed target never answers.
// PARAMETERS
// NUM_TARGETS     5    number of target channels (1..16)
// SYNC_STAGES     3    flops on the AS_n sync chain (>=2); UDS/LDS/RW use SYNC_STAGES-1
// TIMEOUT_CYCLES  255  MEMCLK cycles allowed in START+DATA before BERR (>=4)
// TIMEOUT_EN      1    0 = watchdog removed, berr tied 0
// PORTS
// MEMCLK          in   1   sole clock; all state on posedge
// RESET_n         in   1   asynchronous active-low reset
// AS_n            in   1   raw bus address strobe (async)
// UDS_n           in   1   raw upper data strobe (async)
// LDS_n           in   1   raw lower data strobe (async)
// RW              in   1   raw read/write (async, 1=read)
// target_sel      in   N   per-target combinational address decode hit
// target_ready    in   N   per-target "data done" (level, MEMCLK domain)
// target_imm      in   N   per-target immediate-ack (no wait), e.g. control regs
// as_n_s          out  1   AS_n after SYNC_STAGES-1 flops (for targets)
// uds_n_s/lds_n_s out  1   synchronised strobes (SYNC_STAGES-1 flops)
// rw_s            out  1   synchronised RW (SYNC_STAGES-1 flops)
// z2_state        out  2   00 IDLE, 01 START, 10 DATA, 11 END (ERR reports 11)
// active_target   out  N   one-hot claimed target, 0 when IDLE
// dtack           out  1   registered DTACK request (top level gates pin drive)
// berr            out  1   registered bus-error request
// multi_hit       out  1   1-cycle pulse: >1 target_sel bit set at claim
// BEHAVIOUR
// - Reset: all sync flops 1 (rw_s 1), state IDLE, active_target 0, dtack 0, berr 0,
//   multi_hit 0, timer 0. Reset asserted mid-cycle aborts immediately, no dtack.
// - IDLE: when AS_n sync final stage==0 and |target_sel: claim lowest set index of
//   target_sel into active_target, -> START; multi_hit pulses if popcount>1. No hit:
//   stay IDLE, no output change (cycle belongs to someone else).
// - START: -> DATA when uds_n_s==0 or lds_n_s==0.
// - DATA: if (target_ready|target_imm) & active_target != 0: dtack<=1, -> END.
// - END: hold dtack until as_n_s==1, then dtack<=0, active_target<=0, -> IDLE.
// - Abort: as_n_s==1 while in START or DATA -> IDLE next edge, dtack never asserted,
//   active_target cleared, timer cleared.
// - Watchdog (TIMEOUT_EN=1): timer width $clog2(TIMEOUT_CYCLES+1); clears in IDLE,
//   increments each cycle in START/DATA, saturates. When timer==TIMEOUT_CYCLES-1 and no
//   ack that cycle: berr<=1, -> ERR. Ack and timeout on the same edge: ack wins.
// - ERR: z2_state=11, dtack=0, berr held until as_n_s==1, then berr<=0 -> IDLE.
// - Latency: raw AS_n fall to START = SYNC_STAGES+1 edges; target_ready to dtack = 1.
// - target_sel changes after claim are ignored until next IDLE.
// TESTING
// 1 Read, sel=00100, ready 3 clk after DATA -> active_target=00100, dtack 1 clk after
//   ready, held to AS_n rise, z2_state 0->1->2->3->0.
// 2 sel=00101, target_imm[0]=1 -> claims 00001, multi_hit 1-clk pulse, dtack 1 clk
//   after DATA entry.
// 3 TIMEOUT_CYCLES=8, sel=00010, ready never -> berr after 8 START+DATA clks,
//   dtack stays 0, berr clears 1 clk after as_n_s rises.
// 4 AS_n rises in DATA before ready -> IDLE next edge, no dtack, next cycle normal.
// 5 RESET_n low in END with dtack=1 -> dtack, berr, active_target 0 without clock.
// 6 sel=0 with AS_n low 20 clks -> state IDLE throughout, dtack=berr=0.

Source files
------------

// File: rtl/z2_cycle_ctrl.sv
// Zorro II slave bus-cycle controller: strobe synchronisation, target claim,
// IDLE/START/DATA/END sequencing with abort, multi-hit flagging and BERR watchdog.
module z2_cycle_ctrl #(
    parameter int unsigned NUM_TARGETS    = 5,
    parameter int unsigned SYNC_STAGES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          TIMEOUT_EN     = 1'b1
) (
    input  logic                   MEMCLK,
    input  logic                   RESET_n,
    input  logic                   AS_n,
    input  logic                   UDS_n,
    input  logic                   LDS_n,
    input  logic                   RW,
    input  logic [NUM_TARGETS-1:0] target_sel,
    input  logic [NUM_TARGETS-1:0] target_ready,
    input  logic [NUM_TARGETS-1:0] target_imm,
    output logic                   as_n_s,
    output logic                   uds_n_s,
    output logic                   lds_n_s,
    output logic                   rw_s,
    output logic [1:0]             z2_state,
    output logic [NUM_TARGETS-1:0] active_target,
    output logic                   dtack,
    output logic                   berr,
    output logic                   multi_hit
);

    localparam int unsigned STRB_STAGES = SYNC_STAGES - 1;
    localparam int unsigned TIMER_W     = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_END,
        ST_ERR
    } state_t;

    state_t                   state, state_nxt;
    logic [NUM_TARGETS-1:0]   tgt_nxt;
    logic                     dtack_nxt;
    logic                     berr_nxt;
    logic                     mh_nxt;
    logic [TIMER_W-1:0]       timer, timer_nxt, timer_inc;
    logic                     timeout;
    logic                     ack;
    logic                     as_fin;

    logic [SYNC_STAGES-1:0]   as_sync;
    logic [STRB_STAGES-1:0]   uds_sync;
    logic [STRB_STAGES-1:0]   lds_sync;
    logic [STRB_STAGES-1:0]   rw_sync;

    // Lowest-index hit wins the claim.
    function automatic logic [NUM_TARGETS-1:0] lowest_hit(input logic [NUM_TARGETS-1:0] v);
        logic [NUM_TARGETS-1:0] r;
        logic                   found;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic more_than_one(input logic [NUM_TARGETS-1:0] v);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
            if (v[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen = 1'b1;
            end
        end
        return multi;
    endfunction

    // ERR is reported to the bus side as END.
    function automatic logic [1:0] state_code(input state_t s);
        case (s)
            ST_IDLE:  return 2'b00;
            ST_START: return 2'b01;
            ST_DATA:  return 2'b10;
            default:  return 2'b11;
        endcase
    endfunction

    // Strobe synchronisers; all idle high out of reset.
    always_ff @(posedge MEMCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            as_sync  <= '1;
            uds_sync <= '1;
            lds_sync <= '1;
            rw_sync  <= '1;
        end else begin
            as_sync[0]  <= AS_n;
            uds_sync[0] <= UDS_n;
            lds_sync[0] <= LDS_n;
            rw_sync[0]  <= RW;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                as_sync[i] <= as_sync[i-1];
            end
            for (int unsigned i = 1; i < STRB_STAGES; i++) begin
                uds_sync[i] <= uds_sync[i-1];
                lds_sync[i] <= lds_sync[i-1];
                rw_sync[i]  <= rw_sync[i-1];
            end
        end
    end

    // Targets see AS one stage earlier than the claim logic, so the abort/release
    // path reacts a cycle ahead of a fresh claim.
    assign as_n_s  = as_sync[SYNC_STAGES-2];
    assign as_fin  = as_sync[SYNC_STAGES-1];
    assign uds_n_s = uds_sync[STRB_STAGES-1];
    assign lds_n_s = lds_sync[STRB_STAGES-1];
    assign rw_s    = rw_sync[STRB_STAGES-1];

    assign ack       = |((target_ready | target_imm) & active_target);
    assign timer_inc = (timer == TIMER_W'(TIMEOUT_CYCLES)) ? timer : timer + TIMER_W'(1);
    assign timeout   = TIMEOUT_EN && (timer == TIMER_W'(TIMEOUT_CYCLES - 1));

    // State register and registered outputs.
    always_ff @(posedge MEMCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state         <= ST_IDLE;
            z2_state      <= 2'b00;
            active_target <= '0;
            dtack         <= 1'b0;
            berr          <= 1'b0;
            multi_hit     <= 1'b0;
            timer         <= '0;
        end else begin
            state         <= state_nxt;
            z2_state      <= state_code(state_nxt);
            active_target <= tgt_nxt;
            dtack         <= dtack_nxt;
            berr          <= berr_nxt;
            multi_hit     <= mh_nxt;
            timer         <= timer_nxt;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt = state;
        tgt_nxt   = active_target;
        dtack_nxt = dtack;
        berr_nxt  = berr;
        mh_nxt    = 1'b0;
        timer_nxt = '0;

        case (state)
            ST_IDLE: begin
                dtack_nxt = 1'b0;
                berr_nxt  = 1'b0;
                tgt_nxt   = '0;
                if (!as_fin && (|target_sel)) begin
                    tgt_nxt   = lowest_hit(target_sel);
                    mh_nxt    = more_than_one(target_sel);
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (as_n_s) begin
                    tgt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else if (timeout) begin
                    berr_nxt  = 1'b1;
                    state_nxt = ST_ERR;
                end else begin
                    timer_nxt = TIMEOUT_EN ? timer_inc : '0;
                    if (!uds_n_s || !lds_n_s) begin
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (as_n_s) begin
                    tgt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else if (ack) begin
                    dtack_nxt = 1'b1;
                    state_nxt = ST_END;
                end else if (timeout) begin
                    berr_nxt  = 1'b1;
                    state_nxt = ST_ERR;
                end else begin
                    timer_nxt = TIMEOUT_EN ? timer_inc : '0;
                end
            end
            ST_END: begin
                if (as_n_s) begin
                    dtack_nxt = 1'b0;
                    tgt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end
            end
            ST_ERR: begin
                dtack_nxt = 1'b0;
                if (as_n_s) begin
                    berr_nxt  = 1'b0;
                    tgt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                dtack_nxt = 1'b0;
                berr_nxt  = 1'b0;
                tgt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_z2_cycle_ctrl.sv
// Scoreboard bench for z2_cycle_ctrl: stimulus queues expected output snapshots,
// a negedge monitor pops one whenever the observed output tuple changes.
module tb_z2_cycle_ctrl;

    localparam int unsigned N = 5;

    logic         MEMCLK = 1'b0;
    logic         RESET_n;
    logic         AS_n, UDS_n, LDS_n, RW;
    logic [N-1:0] target_sel, target_ready, target_imm;
    logic         as_n_s, uds_n_s, lds_n_s, rw_s;
    logic [1:0]   z2_state;
    logic [N-1:0] active_target;
    logic         dtack, berr, multi_hit;

    always #5 MEMCLK = ~MEMCLK;

    z2_cycle_ctrl #(
        .NUM_TARGETS   (N),
        .SYNC_STAGES   (3),
        .TIMEOUT_CYCLES(8),
        .TIMEOUT_EN    (1'b1)
    ) dut (
        .MEMCLK       (MEMCLK),
        .RESET_n      (RESET_n),
        .AS_n         (AS_n),
        .UDS_n        (UDS_n),
        .LDS_n        (LDS_n),
        .RW           (RW),
        .target_sel   (target_sel),
        .target_ready (target_ready),
        .target_imm   (target_imm),
        .as_n_s       (as_n_s),
        .uds_n_s      (uds_n_s),
        .lds_n_s      (lds_n_s),
        .rw_s         (rw_s),
        .z2_state     (z2_state),
        .active_target(active_target),
        .dtack        (dtack),
        .berr         (berr),
        .multi_hit    (multi_hit)
    );

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic [N-1:0] tgt;
        logic       dt;
        logic       be;
        logic       mh;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   t0;

    logic [1:0]   p_st  = 2'b00;
    logic [N-1:0] p_tgt = '0;
    logic         p_dt  = 1'b0;
    logic         p_be  = 1'b0;
    logic         p_mh  = 1'b0;

    always @(posedge MEMCLK) cyc <= cyc + 1;

    task automatic expect_ev(input int c, input logic [1:0] st, input logic [N-1:0] tgt,
                             input logic dt, input logic be, input logic mh);
        ev_t x;
        x.cyc = c; x.st = st; x.tgt = tgt; x.dt = dt; x.be = be; x.mh = mh;
        exp_q.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge MEMCLK);
            #1;
        end
    endtask

    task automatic bus_start(input logic [N-1:0] sel, input logic rw, output int t);
        @(posedge MEMCLK);
        #1;
        AS_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0; RW = rw; target_sel = sel;
        t = cyc;
    endtask

    task automatic bus_end();
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
        target_sel = '0; target_ready = '0; target_imm = '0;
    endtask

    // Monitor: every change of the observed tuple must match the next queued event.
    always @(negedge MEMCLK) begin
        if ({z2_state, active_target, dtack, berr, multi_hit} !== {p_st, p_tgt, p_dt, p_be, p_mh}) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got st=%b tgt=%b dtack=%b berr=%b mh=%b",
                         cyc, z2_state, active_target, dtack, berr, multi_hit);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.st !== z2_state || e.tgt !== active_target ||
                    e.dt !== dtack || e.be !== berr || e.mh !== multi_hit) begin
                    errors++;
                    $display("FAIL event got cyc=%0d st=%b tgt=%b dtack=%b berr=%b mh=%b required cyc=%0d st=%b tgt=%b dtack=%b berr=%b mh=%b",
                             cyc, z2_state, active_target, dtack, berr, multi_hit,
                             e.cyc, e.st, e.tgt, e.dt, e.be, e.mh);
                end
            end
            p_st = z2_state; p_tgt = active_target; p_dt = dtack; p_be = berr; p_mh = multi_hit;
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        RESET_n = 1'b1;
        AS_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0; RW = 1'b0;
        target_sel = '0; target_ready = '0; target_imm = '0;
        #2 RESET_n = 1'b0;
        #15;
        // Reset values held across clock edges with strobes driven low.
        chk("rst_state", 32'(z2_state), 32'd0);
        chk("rst_tgt", 32'(active_target), 32'd0);
        chk("rst_dtack", 32'(dtack), 32'd0);
        chk("rst_berr", 32'(berr), 32'd0);
        chk("rst_mh", 32'(multi_hit), 32'd0);
        chk("rst_as_n_s", 32'(as_n_s), 32'd1);
        chk("rst_uds_n_s", 32'(uds_n_s), 32'd1);
        chk("rst_lds_n_s", 32'(lds_n_s), 32'd1);
        chk("rst_rw_s", 32'(rw_s), 32'd1);
        bus_end();
        #6 RESET_n = 1'b1;
        goto(6);

        // Read, single hit, claimed target answers late; other targets' ready ignored.
        bus_start(5'b00100, 1'b1, t0);
        expect_ev(t0 + 4,  2'b01, 5'b00100, 1'b0, 1'b0, 1'b0);
        expect_ev(t0 + 5,  2'b10, 5'b00100, 1'b0, 1'b0, 1'b0);
        expect_ev(t0 + 8,  2'b11, 5'b00100, 1'b1, 1'b0, 1'b0);
        expect_ev(t0 + 13, 2'b00, 5'b00000, 1'b0, 1'b0, 1'b0);
        goto(t0 + 5);
        target_ready = 5'b00011;
        goto(t0 + 7);
        target_ready = 5'b00100;
        goto(t0 + 10);
        bus_end();
        goto(t0 + 17);

        // Multi-hit, lowest index wins, immediate ack.
        bus_start(5'b00101, 1'b1, t0);
        target_imm = 5'b00001;
        expect_ev(t0 + 4,  2'b01, 5'b00001, 1'b0, 1'b0, 1'b1);
        expect_ev(t0 + 5,  2'b10, 5'b00001, 1'b0, 1'b0, 1'b0);
        expect_ev(t0 + 6,  2'b11, 5'b00001, 1'b1, 1'b0, 1'b0);
        expect_ev(t0 + 11, 2'b00, 5'b00000, 1'b0, 1'b0, 1'b0);
        goto(t0 + 8);
        bus_end();
        goto(t0 + 15);

        // Watchdog: no answer, berr after 8 START+DATA cycles.
        bus_start(5'b00010, 1'b1, t0);
        expect_ev(t0 + 4,  2'b01, 5'b00010, 1'b0, 1'b0, 1'b0);
        expect_ev(t0 + 5,  2'b10, 5'b00010, 1'b0, 1'b0, 1'b0);
        expect_ev(t0 + 12, 2'b11, 5'b00010, 1'b0, 1'b1, 1'b0);
        expect_ev(t0 + 17, 2'b00, 5'b00000, 1'b0, 1'b0, 1'b0);
        goto(t0 + 14);
        bus_end();
        goto(t0 + 20);

        // Write, aborted in DATA, then a normal cycle.
        bus_start(5'b01000, 1'b0, t0);
        expect_ev(t0 + 4,  2'b01, 5'b01000, 1'b0, 1'b0, 1'b0);
        expect_ev(t0 + 5,  2'b10, 5'b01000, 1'b0, 1'b0, 1'b0);
        expect_ev(t0 + 9,  2'b00, 5'b00000, 1'b0, 1'b0, 1'b0);
        goto(t0 + 2);
        chk("sync_rw_s", 32'(rw_s), 32'd0);
        chk("sync_uds_n_s", 32'(uds_n_s), 32'd0);
        chk("sync_as_n_s", 32'(as_n_s), 32'd0);
        goto(t0 + 6);
        bus_end();
        goto(t0 + 12);

        bus_start(5'b10000, 1'b1, t0);
        target_ready = 5'b10000;
        expect_ev(t0 + 4,  2'b01, 5'b10000, 1'b0, 1'b0, 1'b0);
        expect_ev(t0 + 5,  2'b10, 5'b10000, 1'b0, 1'b0, 1'b0);
        expect_ev(t0 + 6,  2'b11, 5'b10000, 1'b1, 1'b0, 1'b0);
        expect_ev(t0 + 11, 2'b00, 5'b00000, 1'b0, 1'b0, 1'b0);
        goto(t0 + 8);
        bus_end();
        goto(t0 + 14);

        // Asynchronous reset while in END with dtack asserted.
        bus_start(5'b00001, 1'b1, t0);
        target_imm = 5'b00001;
        expect_ev(t0 + 4,  2'b01, 5'b00001, 1'b0, 1'b0, 1'b0);
        expect_ev(t0 + 5,  2'b10, 5'b00001, 1'b0, 1'b0, 1'b0);
        expect_ev(t0 + 6,  2'b11, 5'b00001, 1'b1, 1'b0, 1'b0);
        expect_ev(t0 + 7,  2'b00, 5'b00000, 1'b0, 1'b0, 1'b0);
        goto(t0 + 7);
        #2;
        RESET_n = 1'b0;
        bus_end();
        #1;
        chk("arst_dtack", 32'(dtack), 32'd0);
        chk("arst_berr", 32'(berr), 32'd0);
        chk("arst_tgt", 32'(active_target), 32'd0);
        chk("arst_state", 32'(z2_state), 32'd0);
        goto(t0 + 9);
        RESET_n = 1'b1;
        goto(t0 + 13);

        // Foreign cycle: AS low with no decode hit for 20 clocks.
        @(posedge MEMCLK);
        #1;
        AS_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0; target_sel = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge MEMCLK);
            chk("nohit_state", 32'(z2_state), 32'd0);
            chk("nohit_dtack", 32'(dtack), 32'd0);
            chk("nohit_berr", 32'(berr), 32'd0);
        end
        @(posedge MEMCLK);
        #1;
        bus_end();
        goto(cyc + 6);

        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event required cyc=%0d st=%b tgt=%b dtack=%b berr=%b mh=%b",
                     e.cyc, e.st, e.tgt, e.dt, e.be, e.mh);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
